// File: rtl/jk_ubus_pkg.sv
// jk_ubus_pkg: shared UBUS slave types, constants and burst-length helper
package jk_ubus_pkg;

    localparam int UBUS_SIZE_W    = 2;
    localparam int UBUS_MAX_BEATS = 8;

    typedef enum logic [1:0] {IDLE, WAIT, BEAT, SKIP} slave_state_e;

    function automatic logic [3:0] burst_len(input logic [UBUS_SIZE_W-1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/jk_ubus_wait_gen.sv
// jk_ubus_wait_gen: loadable down-counter marking wait cycles before a beat
module jk_ubus_wait_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] wait_cyc,
    output logic       wait_state,
    output logic       done
);

    logic [3:0] cnt;

    // load the wait budget on entry to WAIT, then count down to zero
    always_ff @(posedge clk or posedge reset)
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= wait_cyc;
        else if (cnt != '0)
            cnt <= cnt - 4'd1;

    assign wait_state = cnt != '0;
    assign done       = cnt == 4'd1;

endmodule

// File: rtl/jk_ubus_slave_mem.sv
// jk_ubus_slave_mem: UBUS memory slave serving 1/2/4/8-beat bursts in a DEPTH window
module jk_ubus_slave_mem
    import jk_ubus_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter int          DATA_W    = 8,
    parameter int          DEPTH     = 256,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          WAIT_CYC  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [UBUS_SIZE_W-1:0] size,
    input  logic                   read,
    input  logic                   write,
    input  logic                   bip,
    input  logic [DATA_W-1:0]      data_in,
    output logic [DATA_W-1:0]      data_out,
    output logic                   data_oe,
    output logic                   wait_state,
    output logic                   error,
    output logic                   proto_err
);

    localparam int MW = $clog2(DEPTH);
    localparam int BW = $clog2(UBUS_MAX_BEATS);

    slave_state_e      state, state_nxt;
    logic [ADDR_W-1:0] base, base_nxt;
    logic [BW-1:0]     len_m1, len_nxt, beat, beat_nxt;
    logic              rd, rd_nxt, ill, ill_nxt;
    logic [ADDR_W-1:0] cur_a, nxt_a;
    logic              wait_load, wait_done, mem_we;
    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic in_win(input logic [ADDR_W-1:0] a);
        return (a - ADDR_W'(BASE_ADDR)) < ADDR_W'(DEPTH);
    endfunction

    function automatic logic [MW-1:0] idx(input logic [ADDR_W-1:0] a);
        return MW'(a - ADDR_W'(BASE_ADDR));
    endfunction

    assign cur_a     = base + ADDR_W'(beat);
    assign nxt_a     = base_nxt + ADDR_W'(beat_nxt);
    assign wait_load = (state_nxt == WAIT) && (state != WAIT);
    assign mem_we    = (state == BEAT) && !rd && !ill && in_win(cur_a) && !reset;

    jk_ubus_wait_gen u_wait (
        .clk        (clk),
        .reset      (reset),
        .load       (wait_load),
        .wait_cyc   (4'(WAIT_CYC)),
        .wait_state (wait_state),
        .done       (wait_done)
    );

    // next-state: latch the transfer in the address phase, step beats, ride out foreign bursts
    always_comb begin
        state_nxt = state;
        base_nxt  = base;
        len_nxt   = len_m1;
        beat_nxt  = beat;
        rd_nxt    = rd;
        ill_nxt   = ill;
        case (state)
            IDLE: if (read || write) begin
                base_nxt  = addr;
                len_nxt   = BW'(burst_len(size) - 4'd1);
                beat_nxt  = '0;
                rd_nxt    = read;
                ill_nxt   = read && write;
                state_nxt = !in_win(addr) ? SKIP : (WAIT_CYC > 0 ? WAIT : BEAT);
            end
            WAIT: state_nxt = wait_done ? BEAT : WAIT;
            BEAT: begin
                beat_nxt  = (beat == len_m1) ? beat : beat + 1'b1;
                state_nxt = (beat == len_m1) ? IDLE : (WAIT_CYC > 0 ? WAIT : BEAT);
            end
            SKIP: state_nxt = bip ? SKIP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state and registered outputs: beat outputs are prepared on entry to BEAT
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            base      <= '0;
            len_m1    <= '0;
            beat      <= '0;
            rd        <= 1'b0;
            ill       <= 1'b0;
            data_out  <= '0;
            data_oe   <= 1'b0;
            error     <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            base      <= base_nxt;
            len_m1    <= len_nxt;
            beat      <= beat_nxt;
            rd        <= rd_nxt;
            ill       <= ill_nxt;
            data_oe   <= (state_nxt == BEAT) && rd_nxt && !ill_nxt;
            error     <= (state_nxt == BEAT) && (ill_nxt || !in_win(nxt_a));
            data_out  <= ((state_nxt == BEAT) && rd_nxt && !ill_nxt && in_win(nxt_a)) ? mem[idx(nxt_a)] : '0;
            if ((state == BEAT) && (bip != (beat != len_m1)))
                proto_err <= 1'b1;
        end

    // memory write port; contents survive reset
    always_ff @(posedge clk)
        if (mem_we)
            mem[idx(cur_a)] <= data_in;

endmodule
